// File: rtl/soc_system_pio_capture_pkg.sv
// Shared constants and types for the soc_system PIO capture block.
// The optional event counter is enabled with the PIO_CAPTURE_EVCNT_EN macro.
package soc_system_pio_capture_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_SYNC  = 4;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EVCNT    = 3'd5;
    localparam logic [2:0] ADDR_SNAPSHOT = 3'd6;

    typedef enum logic {
        WARMUP = 1'b0,
        ARMED  = 1'b1
    } arm_state_t;

endpackage

// File: rtl/soc_system_pio_capture_if.sv
// Avalon-MM slave bus bundle for the PIO capture block, plus its interrupt line.
interface soc_system_pio_capture_if;
    import soc_system_pio_capture_pkg::*;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

endinterface

// File: rtl/soc_system_pio_sync.sv
// WIDTH-wide multi-flop synchroniser for asynchronous fabric inputs.
module soc_system_pio_sync
    import soc_system_pio_capture_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                s[i] <= '0;
            end
        end else begin
            s[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_capture.sv
// Avalon-MM input PIO with per-bit rise/fall capture, maskable irq and snapshot.
// Define PIO_CAPTURE_EVCNT_EN to add the saturating 32-bit event counter at address 5.
module soc_system_pio_capture
    import soc_system_pio_capture_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter int               SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] RISE_EN_RESET = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] FALL_EN_RESET = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    soc_system_pio_capture_if.slave  bus,
    input  logic [WIDTH-1:0]         in_port
);

    localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] s_last;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] snapshot;

    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] mask_next;
    logic             wr_en;
    logic             any_hit;
    logic [31:0]      evcnt_rd;
    logic [31:0]      rd_mux;

    arm_state_t       state;
    logic [2:0]       warm_cnt;

    soc_system_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (s_last)
    );

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign wdata_w = bus.writedata[WIDTH-1:0];

    // Edge detect; suppressed until the chain and prev hold real input samples.
    assign rise    = s_last & ~prev & rise_en;
    assign fall    = ~s_last & prev & fall_en;
    assign hit     = (state == ARMED) ? (rise | fall) : '0;
    assign any_hit = |hit;

    assign clr       = (wr_en && bus.address == ADDR_CAPTURE) ? wdata_w : '0;
    assign cap_next  = (cap & ~clr) | hit;
    assign mask_next = (wr_en && bus.address == ADDR_IRQ_MASK) ? wdata_w : irq_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WARMUP;
            warm_cnt <= WARM_LOAD;
        end else if (state == WARMUP) begin
            if (warm_cnt == 3'd0) begin
                state <= ARMED;
            end else begin
                warm_cnt <= warm_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            rise_en  <= RISE_EN_RESET;
            fall_en  <= FALL_EN_RESET;
            irq_mask <= '0;
            cap      <= '0;
            snapshot <= '0;
            bus.irq  <= 1'b0;
        end else begin
            prev     <= s_last;
            cap      <= cap_next;
            irq_mask <= mask_next;
            bus.irq  <= |(cap_next & mask_next);
            if (any_hit) begin
                snapshot <= s_last;
            end
            if (wr_en && bus.address == ADDR_RISE_EN) begin
                rise_en <= wdata_w;
            end
            if (wr_en && bus.address == ADDR_FALL_EN) begin
                fall_en <= wdata_w;
            end
        end
    end

`ifdef PIO_CAPTURE_EVCNT_EN
    logic [31:0] evcnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A clear coinciding with an event still counts that event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evcnt <= '0;
        end else if (wr_en && bus.address == ADDR_EVCNT) begin
            evcnt <= any_hit ? 32'd1 : 32'd0;
        end else if (any_hit) begin
            evcnt <= sat_inc(evcnt);
        end
    end

    assign evcnt_rd = evcnt;
`else
    assign evcnt_rd = 32'd0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (bus.address)
            ADDR_DATA:     rd_mux = 32'(s_last);
            ADDR_RISE_EN:  rd_mux = 32'(rise_en);
            ADDR_FALL_EN:  rd_mux = 32'(fall_en);
            ADDR_CAPTURE:  rd_mux = 32'(cap);
            ADDR_IRQ_MASK: rd_mux = 32'(irq_mask);
            ADDR_EVCNT:    rd_mux = evcnt_rd;
            ADDR_SNAPSHOT: rd_mux = 32'(snapshot);
            default:       rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= 32'd0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_system_pio_capture.sv
// Directed table-driven bench for soc_system_pio_capture (WIDTH=8, SYNC_STAGES=2).
module tb_soc_system_pio_capture;

`ifdef PIO_CAPTURE_EVCNT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    typedef struct {
        logic [7:0]  din;
        logic [2:0]  addr;
        bit          wr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          irq;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_port;
    int         total = 0;
    int         bad   = 0;
    vec_t       tbl[$];

    soc_system_pio_capture_if bus();

    soc_system_pio_capture #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ev(input logic [31:0] n);
        return EV ? n : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] din, input logic [2:0] addr, input bit wr,
                       input logic [31:0] wd, input logic [31:0] rd, input bit irq);
        vec_t v;
        v.din = din; v.addr = addr; v.wr = wr; v.wd = wd; v.rd = rd; v.irq = irq;
        tbl.push_back(v);
    endtask

    // One bus cycle, starting and ending at a falling edge.
    task automatic cyc(input logic [7:0] din, input logic [2:0] a, input bit wr, input logic [31:0] wd);
        in_port       = din;
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = ~wr;
        bus.writedata  = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        in_port        = 8'hFF;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;

        // Scenario 1 vectors onwards: {din, addr, wr, wdata, expected readdata, expected irq}
        add(8'h00, 3'd1, 1, 32'h01, 32'hFF, 0);
        add(8'h00, 3'd2, 1, 32'h00, 32'h00, 0);
        add(8'h00, 3'd4, 1, 32'h01, 32'h00, 0);
        add(8'h00, 3'd0, 0, 32'h00, 32'h00, 0);
        add(8'h01, 3'd3, 0, 32'h00, 32'h00, 0);
        add(8'h01, 3'd0, 0, 32'h00, 32'h00, 0);
        add(8'h01, 3'd3, 0, 32'h00, 32'h00, 1);
        add(8'h01, 3'd3, 0, 32'h00, 32'h01, 1);
        add(8'h01, 3'd6, 0, 32'h00, 32'h01, 1);
        add(8'h00, 3'd5, 0, 32'h00, ev(1), 1);
        add(8'h00, 3'd5, 0, 32'h00, ev(1), 1);
        add(8'h00, 3'd5, 0, 32'h00, ev(1), 1);
        add(8'h00, 3'd5, 0, 32'h00, ev(1), 1);
        add(8'h00, 3'd3, 1, 32'h01, 32'h01, 0);
        add(8'h00, 3'd1, 1, 32'h00, 32'h01, 0);
        add(8'hFF, 3'd2, 1, 32'h80, 32'h00, 0);
        add(8'hFF, 3'd4, 1, 32'h80, 32'h01, 0);
        add(8'hFF, 3'd0, 0, 32'h00, 32'hFF, 0);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h00, 0);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h00, 0);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h00, 1);
        add(8'h7F, 3'd6, 0, 32'h00, 32'h7F, 1);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h80, 1);
        add(8'h7F, 3'd3, 1, 32'h80, 32'h80, 0);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h00, 0);
        add(8'h7F, 3'd5, 0, 32'h00, ev(2), 0);
        add(8'h7F, 3'd7, 1, 32'hFF, 32'h00, 0);
        add(8'h7F, 3'd4, 0, 32'h00, 32'h80, 0);
        add(8'h7E, 3'd1, 1, 32'h01, 32'h00, 0);
        add(8'h7F, 3'd4, 1, 32'h01, 32'h80, 0);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h00, 0);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h00, 1);
        add(8'h7E, 3'd3, 0, 32'h00, 32'h01, 1);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h01, 1);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h01, 1);
        add(8'h7F, 3'd3, 1, 32'h01, 32'h01, 1);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h01, 1);
        add(8'h7F, 3'd5, 0, 32'h00, ev(4), 1);
        add(8'h7F, 3'd4, 1, 32'h00, 32'h01, 0);
        add(8'h7F, 3'd3, 0, 32'h00, 32'h01, 0);
        add(8'h7F, 3'd5, 1, 32'h00, ev(4), 0);
        add(8'h7F, 3'd5, 0, 32'h00, 32'h00, 0);

        repeat (3) @(negedge clk);
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_irq", 32'(bus.irq), 32'd0);
        reset = 1'b0;

        // Warmup with inputs high: the zeroed chain must not look like a rising edge.
        for (int i = 0; i < 6; i++) begin
            cyc(8'hFF, 3'd3, 1'b0, 32'd0);
            check($sformatf("warm_cap%0d", i), bus.readdata, 32'd0);
            check($sformatf("warm_irq%0d", i), 32'(bus.irq), 32'd0);
        end
        cyc(8'hFF, 3'd0, 1'b0, 32'd0);
        check("warm_data", bus.readdata, 32'hFF);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].din, tbl[i].addr, tbl[i].wr, tbl[i].wd);
            check($sformatf("row%0d_rd", i), bus.readdata, tbl[i].rd);
            check($sformatf("row%0d_irq", i), 32'(bus.irq), 32'(tbl[i].irq));
        end

`ifdef PIO_CAPTURE_EVCNT_EN
        // Saturation: preload near the top, then three bit0 rising edges.
        force dut.evcnt = 32'hFFFF_FFFE;
        #1;
        release dut.evcnt;
        for (int k = 0; k < 3; k++) begin
            cyc(8'h7E, 3'd0, 1'b0, 32'd0);
            cyc(8'h7F, 3'd0, 1'b0, 32'd0);
            cyc(8'h7F, 3'd0, 1'b0, 32'd0);
            cyc(8'h7F, 3'd0, 1'b0, 32'd0);
        end
        cyc(8'h7F, 3'd5, 1'b0, 32'd0);
        check("evcnt_sat", bus.readdata, 32'hFFFF_FFFF);
        cyc(8'h7F, 3'd5, 1'b1, 32'd0);
        cyc(8'h7F, 3'd5, 1'b0, 32'd0);
        check("evcnt_clr", bus.readdata, 32'd0);
`else
        repeat (10) cyc(8'h7F, 3'd5, 1'b0, 32'd0);
        check("evcnt_absent", bus.readdata, 32'd0);
`endif

        // Reset mid-operation with a pending masked capture.
        cyc(8'h7F, 3'd4, 1'b1, 32'h01);
        check("pre_rst_irq", 32'(bus.irq), 32'd1);
        cyc(8'h7F, 3'd3, 1'b0, 32'd0);
        check("pre_rst_cap", bus.readdata, 32'h01);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rd", bus.readdata, 32'd0);
        check("mid_rst_irq", 32'(bus.irq), 32'd0);
        in_port = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(8'hFF, 3'd3, 1'b0, 32'd0);
            check($sformatf("rewarm_cap%0d", i), bus.readdata, 32'd0);
            check($sformatf("rewarm_irq%0d", i), 32'(bus.irq), 32'd0);
        end
        cyc(8'hFF, 3'd1, 1'b0, 32'd0);
        check("rst_rise_en", bus.readdata, 32'hFF);
        cyc(8'hFF, 3'd4, 1'b0, 32'd0);
        check("rst_mask", bus.readdata, 32'h00);
        cyc(8'hFF, 3'd5, 1'b0, 32'd0);
        check("rst_evcnt", bus.readdata, 32'h00);
        cyc(8'hFF, 3'd6, 1'b0, 32'd0);
        check("rst_snap", bus.readdata, 32'h00);
        cyc(8'hFF, 3'd2, 1'b0, 32'd0);
        check("rst_fall_en", bus.readdata, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
